cnn_image_feeder: RTL

- Upstream stage of the CNN MNIST core (chip_synth).
- Accepts 8-bit pixel bytes over a valid/ready stream into a two-bank ping-pong image buffer, 784 bytes per bank.
- Plays each complete image into the core one pixel per clock, preceded by a one-cycle core reset pulse.
- Waits for the core's valid_out_6, then captures the 4-bit decision as a result pulse. This replaces per-image sequencing currently done in simulation only.

---
 rtl/cnn_image_feeder.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/cnn_image_feeder.sv
// cnn_image_feeder
// Front end of the CNN MNIST core. Pixel bytes arrive on a valid/ready stream
// and fill a two-bank ping-pong image buffer. Each complete image is played
// into the core one pixel per clock, after a one-cycle core reset pulse. The
// feeder then waits for the core's done strobe and captures its 4-bit decision.
module cnn_image_feeder #(
  parameter int PIX_W      = 8,
  parameter int IMG_PIXELS = 784,
  parameter int ADDR_W     = 10,
  parameter int CNT_W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [PIX_W-1:0]  s_data,
  output logic              s_ready,
  output logic              core_rst_n,
  output logic [PIX_W-1:0]  pix_out,
  output logic              pix_valid,
  input  logic              core_done,
  input  logic [3:0]        decision_in,
  output logic              result_valid,
  output logic [3:0]        result,
  output logic [CNT_W-1:0]  img_count,
  output logic              err_early_done
);

  // The buffer holds both banks; the bank bit is the MSB of the word index.
  localparam int MEM_DEPTH = 2 ** (ADDR_W + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_PIXELS - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CORE_RST  = 2'd1,
    ST_STREAM    = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  // Image storage (no reset: contents are only meaningful behind a full flag)
  logic [PIX_W-1:0]  mem_q [MEM_DEPTH];

  state_t            state_q, state_d;
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic [PIX_W-1:0]  pix_out_q, pix_out_d;
  logic              pix_valid_q, pix_valid_d;
  logic [3:0]        result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic [CNT_W-1:0]  img_count_q, img_count_d;
  logic              err_q, err_d;

  logic              wr_en_s;
  logic              wr_last_s;
  logic              rd_en_s;
  logic              release_s;
  logic              early_s;

  // The writer may only target a bank that the reader has released.
  assign s_ready = ~full_q[wr_bank_q];

  // Write-side address and bank sequencing
  always_comb begin
    wr_en_s   = s_valid & ~full_q[wr_bank_q];
    wr_last_s = wr_en_s & (wr_addr_q == LAST_ADDR);
    wr_addr_d = wr_addr_q;
    wr_bank_d = wr_bank_q;
    if (wr_last_s) begin
      wr_addr_d = '0;
      wr_bank_d = ~wr_bank_q;
    end else if (wr_en_s) begin
      wr_addr_d = wr_addr_q + ADDR_W'(1);
    end else begin
      wr_addr_d = wr_addr_q;
    end
  end

  // Read sequencer: next state, read address, release and early-done detection
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_bank_d = rd_bank_q;
    rd_en_s   = 1'b0;
    release_s = 1'b0;
    early_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        early_s = core_done;
        if (full_q[rd_bank_q]) begin
          state_d = ST_CORE_RST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CORE_RST: begin
        early_s   = core_done;
        rd_addr_d = '0;
        state_d   = ST_STREAM;
      end
      ST_STREAM: begin
        early_s = core_done;
        rd_en_s = 1'b1;
        if (rd_addr_q == LAST_ADDR) begin
          rd_addr_d = '0;
          state_d   = ST_WAIT_DONE;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        // The last pixel is still on the wire during the first cycle here;
        // a done strobe that early cannot belong to this image.
        if (pix_valid_q) begin
          early_s = core_done;
        end else if (core_done) begin
          release_s = 1'b1;
          rd_bank_d = ~rd_bank_q;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bank flags, pixel output, result capture and error flag
  always_comb begin
    full_d = full_q;
    if (release_s) begin
      full_d[rd_bank_q] = 1'b0;
    end else begin
      full_d = full_q;
    end
    // Writer and reader always address different banks when both fire.
    if (wr_last_s) begin
      full_d[wr_bank_q] = 1'b1;
    end else begin
      full_d[wr_bank_q] = full_d[wr_bank_q];
    end

    core_rst_n_d = (state_d != ST_CORE_RST);
    pix_valid_d  = rd_en_s;
    if (rd_en_s) begin
      pix_out_d = mem_q[{rd_bank_q, rd_addr_q}];
    end else begin
      pix_out_d = pix_out_q;
    end

    result_valid_d = release_s;
    if (release_s) begin
      result_d    = decision_in;
      img_count_d = img_count_q + CNT_W'(1);
    end else begin
      result_d    = result_q;
      img_count_d = img_count_q;
    end

    err_d = err_q | early_s;
  end

  // Buffer write port
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[{wr_bank_q, wr_addr_q}] <= s_data;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      full_q         <= 2'b00;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b0;
      wr_addr_q      <= '0;
      rd_addr_q      <= '0;
      core_rst_n_q   <= 1'b1;
      pix_out_q      <= '0;
      pix_valid_q    <= 1'b0;
      result_q       <= 4'd0;
      result_valid_q <= 1'b0;
      img_count_q    <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      full_q         <= full_d;
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      wr_addr_q      <= wr_addr_d;
      rd_addr_q      <= rd_addr_d;
      core_rst_n_q   <= core_rst_n_d;
      pix_out_q      <= pix_out_d;
      pix_valid_q    <= pix_valid_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      img_count_q    <= img_count_d;
      err_q          <= err_d;
    end
  end

  assign core_rst_n     = core_rst_n_q;
  assign pix_out        = pix_out_q;
  assign pix_valid      = pix_valid_q;
  assign result         = result_q;
  assign result_valid   = result_valid_q;
  assign img_count      = img_count_q;
  assign err_early_done = err_q;

endmodule
